// File: rtl/max7219_receiver.sv
// -----------------------------------------------------------------------------
// max7219_receiver
//   Receives MAX7219-style serial frames on DIN/SCLK/CS. SCLK and CS are
//   asynchronous to clk. Each 16-bit frame is applied to a register file that
//   mirrors the MAX7219 digit and control registers. Used for loopback
//   self-test and for on-chip display emulation.
//
//   Optional feature macro: MAX7219_RX_DOUT_EN
//     defined   - daisy-chain mode. DOUT carries shift[15], and frames of 16
//                 or more bits are accepted. The last 16 bits shifted in are
//                 the ones committed.
//     undefined - DOUT is tied low, and only exactly-16-bit frames are
//                 accepted.
//
// Ports
//   clk, rst_n    system clock (rising edge); asynchronous active-low reset
//   DIN/SCLK/CS   serial input pins (MSB first, CS active low)
//   row_sel       row readback select (0 selects digit register 0x1)
//   row_q         combinational readback of digit register row_sel+1
//   shutdown_n    reg 0xC bit0
//   decode_mode   reg 0x9
//   intensity     reg 0xA[3:0]
//   scan_limit    reg 0xB[2:0]
//   display_test  reg 0xF bit0
//   frame_valid   one-cycle pulse when a frame is accepted
//   frame_err     one-cycle pulse when a frame is rejected
//   last_addr     address nibble of the last accepted frame
//   DOUT          daisy-chain serial output
// -----------------------------------------------------------------------------
module max7219_receiver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       DIN,
    input  logic       SCLK,
    input  logic       CS,
    input  logic [2:0] row_sel,
    output logic [7:0] row_q,
    output logic       shutdown_n,
    output logic [7:0] decode_mode,
    output logic [3:0] intensity,
    output logic [2:0] scan_limit,
    output logic       display_test,
    output logic       frame_valid,
    output logic       frame_err,
    output logic [3:0] last_addr,
    output logic       DOUT
);

    typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

    logic [1:0]       din_s;
    logic [2:0]       sclk_s;
    logic [2:0]       cs_s;
    // live[k] is set once sync stage k+1 holds a genuine pin sample rather
    // than its reset value.
    logic [2:0]       live;
    state_t           state_q, state_d;
    logic [15:0]      shift_q;
    logic [4:0]       cnt_q;
    logic [7:0][7:0]  digit_q;
    logic             clr, shift_en, commit, accept;
    logic             sclk_rise, cs_fall, cs_rise;
    logic [3:0]       addr;
    logic [7:0]       data;
    logic [2:0]       row_idx;
    logic             unused_bits;

    // Input synchronisers. The CS stages reset high, so that CS reads as
    // idle until the real pin level arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_s  <= 2'b00;
            sclk_s <= 3'b000;
            cs_s   <= 3'b111;
            live   <= 3'b000;
        end else begin
            din_s  <= {din_s[0], DIN};
            sclk_s <= {sclk_s[1:0], SCLK};
            cs_s   <= {cs_s[1:0], CS};
            live   <= {live[1:0], 1'b1};
        end
    end

    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign cs_rise   = cs_s[1] & ~cs_s[2];
    // The reset value of cs_s[2] must not count as "high". If CS is already
    // low when reset is released, that is not a falling edge.
    assign cs_fall   = ~cs_s[1] & cs_s[2] & live[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A CS rise takes priority over an SCLK rise in the same cycle. The SCLK
    // edge is dropped, and the frame is judged on the count seen so far.
    always_comb begin
        state_d  = state_q;
        clr      = 1'b0;
        shift_en = 1'b0;
        commit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    clr     = 1'b1;
                    state_d = ARMED;
                end
            end
            ARMED, SHIFT: begin
                if (cs_rise) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                    state_d  = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clr) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (shift_en) begin
            shift_q <= {shift_q[14:0], din_s[1]};
            if (cnt_q != 5'd31) cnt_q <= cnt_q + 5'd1;
        end
    end

`ifdef MAX7219_RX_DOUT_EN
    logic sclk_fall;
    assign sclk_fall   = ~sclk_s[1] & sclk_s[2];
    assign accept      = (cnt_q >= 5'd16);
    assign unused_bits = ^shift_q[14:12];

    // Data leaves on the SCLK falling edge, which gives the next device a
    // full low phase of setup time before its rising-edge sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        DOUT <= 1'b0;
        else if (sclk_fall && !cs_s[1] && state_q != IDLE) DOUT <= shift_q[15];
    end
`else
    assign accept      = (cnt_q == 5'd16);
    assign unused_bits = ^shift_q[15:12];
    assign DOUT        = 1'b0;
`endif

    assign addr    = shift_q[11:8];
    assign data    = shift_q[7:0];
    // Addresses 0x1..0x8 map to rows 0..7. Address 8 wraps from 3'b000 to 7.
    assign row_idx = addr[2:0] - 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q      <= '0;
            shutdown_n   <= 1'b0;
            decode_mode  <= 8'h00;
            intensity    <= 4'h0;
            scan_limit   <= 3'h0;
            display_test <= 1'b0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
            last_addr    <= 4'h0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (commit) begin
                if (accept) begin
                    frame_valid <= 1'b1;
                    last_addr   <= addr;
                    case (addr)
                        4'h1, 4'h2, 4'h3, 4'h4,
                        4'h5, 4'h6, 4'h7, 4'h8: digit_q[row_idx] <= data;
                        4'h9:    decode_mode  <= data;
                        4'hA:    intensity    <= data[3:0];
                        4'hB:    scan_limit   <= data[2:0];
                        4'hC:    shutdown_n   <= data[0];
                        4'hF:    display_test <= data[0];
                        default: ;  // 0x0, 0xD, 0xE: accepted, no effect
                    endcase
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    assign row_q = digit_q[row_sel];

endmodule

// File: tb/tb_max7219_receiver.sv
module tb_max7219_receiver;

    logic       clk = 1'b0, rst_n = 1'b1, DIN = 1'b0, SCLK = 1'b0, CS = 1'b1;
    logic [2:0] row_sel = 3'd0;
    logic [7:0] row_q, decode_mode;
    logic       shutdown_n, display_test, frame_valid, frame_err, DOUT;
    logic [3:0] intensity, last_addr;
    logic [2:0] scan_limit;

    max7219_receiver dut (
        .clk(clk), .rst_n(rst_n), .DIN(DIN), .SCLK(SCLK), .CS(CS),
        .row_sel(row_sel), .row_q(row_q), .shutdown_n(shutdown_n),
        .decode_mode(decode_mode), .intensity(intensity),
        .scan_limit(scan_limit), .display_test(display_test),
        .frame_valid(frame_valid), .frame_err(frame_err),
        .last_addr(last_addr), .DOUT(DOUT)
    );

    always #5 clk = ~clk;

`ifdef MAX7219_RX_DOUT_EN
    localparam bit DAISY = 1'b1;
`else
    localparam bit DAISY = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int n_err  = 0;

    // Behavioural model: register file contents and a queue of expected
    // per-frame outcomes. Each outcome is pushed at the moment CS rises.
    logic [7:0] m_dig[8];
    logic [7:0] m_dec  = 8'h00;
    logic [3:0] m_int  = 4'h0, m_last = 4'h0;
    logic [2:0] m_scan = 3'h0;
    logic       m_shdn = 1'b0, m_test = 1'b0;
    typedef struct { bit ok; logic [15:0] val; } exp_t;
    exp_t expq[$];

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_dig[i] = 8'h00;
        m_dec = 8'h00; m_int = 4'h0; m_scan = 3'h0;
        m_shdn = 1'b0; m_test = 1'b0; m_last = 4'h0;
        expq.delete();
    endfunction

    function automatic void apply(input logic [15:0] v);
        int a;
        a = int'(v[11:8]);
        m_last = v[11:8];
        if (a >= 1 && a <= 8) m_dig[a-1] = v[7:0];
        else if (a == 9)  m_dec  = v[7:0];
        else if (a == 10) m_int  = v[3:0];
        else if (a == 11) m_scan = v[2:0];
        else if (a == 12) m_shdn = v[0];
        else if (a == 15) m_test = v[0];
    endfunction

    // A frame of m bits is accepted if m is exactly 16, or, in daisy mode,
    // if m is 16 or more.
    function automatic void push(input int m, input logic [15:0] v);
        exp_t e;
        e.ok  = DAISY ? (m >= 16) : (m == 16);
        e.val = v;
        expq.push_back(e);
    endfunction

    // Compare process: checks every DUT output against the model on each cycle.
    always @(negedge clk) begin
        if (frame_valid || frame_err) begin
            if (frame_err) n_err++;
            if (expq.size() == 0) begin
                chk("unexpected_pulse", {30'd0, frame_valid, frame_err}, 32'd0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("pulse", {30'd0, frame_valid, frame_err},
                    e.ok ? 32'd2 : 32'd1);
                if (e.ok) apply(e.val);
            end
        end
        chk("shutdown_n",   shutdown_n,   m_shdn);
        chk("decode_mode",  decode_mode,  m_dec);
        chk("intensity",    intensity,    m_int);
        chk("scan_limit",   scan_limit,   m_scan);
        chk("display_test", display_test, m_test);
        chk("last_addr",    last_addr,    m_last);
        chk("row_q",        row_q,        m_dig[row_sel]);
        if (!DAISY) chk("dout_tied", DOUT, 1'b0);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic drain();
        int t = 0;
        while (expq.size() != 0 && t < 30) begin
            @(posedge clk);
            t++;
        end
        chk("drain_timeout", expq.size(), 0);
        cyc(3);
    endtask

    // Shift the n low bits of d, MSB first. With simul set, the final SCLK
    // rise and the CS rise are driven at the same instant. That last SCLK
    // edge must then be dropped.
    task automatic send(input int n, input logic [31:0] d, input bit simul);
        CS = 1'b0;
        cyc(3);
        for (int i = n - 1; i >= 0; i--) begin
            DIN = d[i];
            row_sel = 3'($urandom_range(0, 7));
            cyc(2);
            if (DAISY && (n - i) > 16) begin
                #1;
                chk("dout", DOUT, d[i+16]);
            end
            if (simul && i == 0) begin
                SCLK = 1'b1;
                CS   = 1'b1;
            end else begin
                SCLK = 1'b1;
                cyc($urandom_range(2, 4));
                SCLK = 1'b0;
                cyc($urandom_range(2, 4));
            end
        end
        if (simul) begin
            push(n - 1, d[16:1]);
            cyc(3);
            SCLK = 1'b0;
        end else begin
            CS = 1'b1;
            push(n, d[15:0]);
        end
        drain();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int lens[8] = '{8, 15, 16, 16, 16, 16, 17, 24};
        model_reset();
        #1 rst_n = 1'b0;
        cyc(3);
        @(posedge clk); #2;
        rst_n = 1'b1;
        cyc(4);
        chk("reset_shdn", shutdown_n, 1'b0);
        chk("reset_last", last_addr, 4'h0);

        // Shutdown register
        send(16, 32'h0C01, 1'b0);
        chk("t1_model_shdn", m_shdn, 1'b1);
        chk("t1_shdn",  shutdown_n, 1'b1);
        chk("t1_last",  last_addr, 4'hC);
        chk("t1_int",   intensity, 4'h0);
        chk("t1_dec",   decode_mode, 8'h00);

        // Digit register readback
        send(16, 32'h0318, 1'b0);
        @(posedge clk); row_sel = 3'd2; @(negedge clk);
        chk("t2_row2", row_q, 8'h18);
        @(posedge clk); row_sel = 3'd0; @(negedge clk);
        chk("t2_row0", row_q, 8'h00);

        // Intensity and scan limit
        send(16, 32'h0A1F, 1'b0);
        send(16, 32'h0B07, 1'b0);
        chk("t3_int",  intensity, 4'hF);
        chk("t3_scan", scan_limit, 3'd7);

        // Short and long frames. The low 16 bits of the long frame repeat
        // the last write, so even daisy-mode acceptance changes nothing visible.
        e0 = n_err;
        send(15, 32'h0A02, 1'b0);
        send(17, 32'h10B07, 1'b0);
        chk("t4_errs", n_err - e0, DAISY ? 1 : 2);
        chk("t4_last", last_addr, 4'hB);
        chk("t4_int",  intensity, 4'hF);

        // Reset mid-frame with CS held low, then a full frame
        CS = 1'b0;
        cyc(3);
        for (int i = 15; i >= 8; i--) begin
            DIN = i[0] ? 1'b0 : (i == 8);
            cyc(2); SCLK = 1'b1; cyc(2); SCLK = 1'b0; cyc(2);
        end
        @(posedge clk); #2;
        model_reset();
        rst_n = 1'b0;
        cyc(3);
        @(posedge clk); #2;
        rst_n = 1'b1;
        cyc(5);
        CS = 1'b1;
        cyc(10);
        row_sel = 3'd0; @(negedge clk);
        chk("t5_row0_after_rst", row_q, 8'h00);
        send(16, 32'h0155, 1'b0);
        @(posedge clk); row_sel = 3'd0; @(negedge clk);
        chk("t5_row0", row_q, 8'h55);

        // Final SCLK edge coincides with the CS rise: the frame is 16 bits
        // (0x0A03), not 17.
        send(17, {15'd0, 16'h0A03, 1'b1}, 1'b1);
        chk("t6_int", intensity, 4'h3);

        if (DAISY) begin
            send(32, 32'h0C01_0A05, 1'b0);
            chk("t7_int",  intensity, 4'h5);
            chk("t7_shdn", shutdown_n, 1'b0);
        end

        // Randomized frames
        for (int k = 0; k < 120; k++) begin
            int n;
            n = lens[$urandom_range(0, 7)];
            send(n, $urandom, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/max7219_receiver.md
# max7219_receiver

Clocked receiver for the MAX7219 serial protocol: samples DIN/SCLK/CS from a MAX7219-style master, assembles 16-bit frames and applies them to a register file that mirrors the MAX7219 digit and control registers. It sits at the far end of the LED-matrix link for loopback self-test and on-chip display emulation. Decoded state is exposed as parallel outputs and a row readback port.

## Interface
- No parameters.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- DIN  in  1  serial data, MSB first; sampled on SCLK rising.
- SCLK  in  1  serial clock, asynchronous to clk.
- CS  in  1  chip select, active low; frame latched on rising edge.
- row_sel  in  3  row readback select (0 = digit register 0x1).
- row_q  out  8  combinational readback of digit register row_sel+1.
- shutdown_n  out  1  register 0xC bit0 (1 = normal operation).
- decode_mode  out  8  register 0x9.
- intensity  out  4  register 0xA bits[3:0].
- scan_limit  out  3  register 0xB bits[2:0].
- display_test  out  1  register 0xF bit0.
- frame_valid  out  1  one-cycle pulse on accepted frame.
- frame_err  out  1  one-cycle pulse on rejected frame.
- last_addr  out  4  address nibble of last accepted frame.
- DOUT  out  1  daisy-chain data out (see Configuration).

## Operation
- Input sync: DIN, SCLK, CS each pass through 2 flops, plus a third flop on SCLK/CS for edge detection. Reset values: CS stages 1, SCLK and DIN stages 0.
- States: IDLE (CS high), ARMED (synced CS falling seen: shift register and bit counter cleared), SHIFT (counting), back to IDLE on synced CS rising.
- SHIFT: each synced SCLK rising shifts synced DIN into bit 0 of the 16-bit shift register; 5-bit bit counter increments, saturating at 31.
- SCLK edges while CS high, or while CS low but not ARMED (CS already low at reset release), are ignored.
- Commit on synced CS rising: address = shift[11:8], data = shift[7:0]; bits 15:12 ignored.
  - 0x1–0x8: digit register addr-1 <= data. 0x9: decode_mode. 0xA: intensity <= data[3:0]. 0xB: scan_limit <= data[2:0]. 0xC: shutdown_n <= data[0]. 0xF: display_test <= data[0].
  - 0x0 (no-op), 0xD, 0xE: no register change, still counted as accepted (frame_valid, last_addr update).
- Reject: bit count ≠ 16 (see Configuration) -> frame_err pulse; no register or last_addr change.
- Reset values: all digit registers 0x00, shutdown_n 0, decode_mode 0x00, intensity 0, scan_limit 0, display_test 0, frame_valid 0, frame_err 0, last_addr 0, DOUT 0, state IDLE.
- Reset mid-frame discards the partial frame; the next frame must start with a fresh CS falling edge.

## Timing
- SCLK high and low phases ≥ 2 clk periods; CS high ≥ 2 clk periods between frames. Faster input is undefined.
- Pin edge to synced edge detect: 3 clk cycles.
- Register outputs and last_addr update on the clk edge at which synced CS rising is detected; frame_valid/frame_err are high for exactly that one cycle.
- row_q follows row_sel combinationally; a row written in cycle N reads back from cycle N+1.
- Simultaneous synced SCLK rising and CS rising in one cycle: the SCLK edge is dropped, the frame is evaluated on the prior count.

## Configuration
- MAX7219_RX_DOUT_EN defined: daisy-chain mode. DOUT = shift[15] registered, updated one clk after each synced SCLK falling edge while CS low. The frame is accepted if count ≥ 16, and the last 16 bits shifted are committed. Counts < 16 are rejected.
- Undefined: DOUT tied 0. Only count == 16 is accepted; anything else pulses frame_err.

## Test plan
- Reset, then shift 0x0C01 -> shutdown_n = 1, frame_valid one pulse, last_addr = 0xC, other registers still at reset.
- Shift 0x0318, set row_sel = 2 -> row_q = 0x18; row_sel = 0 -> row_q = 0x00.
- Shift 0x0A1F then 0x0B07 -> intensity = 0xF, scan_limit = 7.
- 15-bit frame, then 17-bit frame (without macro) -> two frame_err pulses, no register change, last_addr unchanged.
- Assert rst_n low after 8 bits of 0x0155 with CS held low, release, raise CS -> no frame_valid, no frame_err, row 0 = 0x00. A following full 0x0155 frame -> row_q (row_sel 0) = 0x55.
- With MAX7219_RX_DOUT_EN: one 32-bit frame 0x0C01_0A05 -> intensity = 5, shutdown_n unchanged. DOUT emits 0x0C01 MSB first during bits 17–32.
